// File: rtl/program_loader_pkg.sv
// Shared constants and loader FSM encoding.
// Frame layout: SYNC, LEN_HI, LEN_LO, LEN*INSTR_BYTES data bytes, CSUM.
package program_loader_pkg;

  localparam int ROM_WIDTH_DEF = 24;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [ROM_WIDTH_DEF-1:0] NOP_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_ERROR
  } ld_state_t;

endpackage

// File: rtl/program_ram.sv
// Simple dual-port instruction memory: one write port, registered read port.
// Same-address read during a write returns the old word.
module program_ram #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/program_loader.sv
// UART-fed program image loader and instruction fetch front end.
// Holds the core in reset while a frame is loading or after a failed load.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ROM_WIDTH      = ROM_WIDTH_DEF,
  parameter int INSTR_BYTES    = ROM_WIDTH / 8,
  parameter int DEPTH          = 4096,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic [15:0]          i_pc,
  output logic [ROM_WIDTH-1:0] o_ir,
  output logic                 o_is_flashing,
  output logic                 o_load_done,
  output logic                 o_error,
  output logic [15:0]          o_words_loaded
);

  localparam int BC_W = $clog2(INSTR_BYTES) + 1;
  localparam int TM_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(INSTR_BYTES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);

  ld_state_t state_q, state_d;

  logic [7:0]           len_hi_q;
  logic [7:0]           sum_q;
  logic [15:0]          len_q;
  logic [15:0]          word_cnt_q;
  logic [BC_W-1:0]      byte_cnt_q;
  logic [TM_W-1:0]      tmo_q;
  logic [ROM_WIDTH-9:0] asm_q;
  logic [ROM_WIDTH-1:0] wr_data_q;
  logic [ROM_WIDTH-1:0] ram_rdata;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic                 wr_en_q;
  logic                 flash_q;
  logic                 done_q;
  logic                 err_q;
  logic                 rd_ok_q;

  logic                 in_frame;
  logic                 tmo_hit;
  logic                 sync_hit;
  logic                 last_byte;
  logic                 last_word;
  logic                 csum_ok;
  logic                 len_gt;
  logic                 len_zero;
  logic [7:0]           csum_sum;
  logic [15:0]          len_d;
  logic [ROM_WIDTH-1:0] word_d;

  assign in_frame  = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM};
  assign tmo_hit   = in_frame && !i_rx_valid && (tmo_q == TM_LAST);
  assign sync_hit  = i_rx_valid && (i_rx_data == SYNC_BYTE);
  assign last_byte = byte_cnt_q == BC_LAST;
  assign last_word = word_cnt_q == (len_q - 16'd1);
  assign csum_sum  = sum_q + i_rx_data;
  assign csum_ok   = csum_sum == 8'd0;
  assign len_d     = {len_hi_q, i_rx_data};
  assign len_gt    = int'(len_d) > DEPTH;
  assign len_zero  = len_d == 16'd0;
  assign word_d    = {asm_q, i_rx_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = ST_ERROR;
    end else if (i_rx_valid) begin
      unique case (state_q)
        ST_IDLE,
        ST_ERROR:  if (sync_hit) state_d = ST_LEN_HI;
        ST_LEN_HI: state_d = ST_LEN_LO;
        ST_LEN_LO: begin
          unique case (1'b1)
            len_gt:   state_d = ST_ERROR;
            len_zero: state_d = ST_CSUM;
            default:  state_d = ST_DATA;
          endcase
        end
        ST_DATA:   if (last_byte && last_word) state_d = ST_CSUM;
        ST_CSUM:   state_d = csum_ok ? ST_IDLE : ST_ERROR;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_hi_q   <= '0;
      sum_q      <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      asm_q      <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      flash_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      rd_ok_q <= (int'(i_pc) < DEPTH) && !flash_q;
      if (in_frame && !i_rx_valid) tmo_q <= tmo_q + 1'b1;
      else                         tmo_q <= '0;
      if (i_rx_valid) begin
        unique case (state_q)
          ST_IDLE,
          ST_ERROR: begin
            if (sync_hit) begin
              flash_q    <= 1'b1;
              err_q      <= 1'b0;
              word_cnt_q <= '0;
              sum_q      <= '0;
              byte_cnt_q <= '0;
            end
          end
          ST_LEN_HI: len_hi_q <= i_rx_data;
          ST_LEN_LO: len_q <= len_d;
          ST_DATA: begin
            sum_q <= csum_sum;
            asm_q <= word_d[ROM_WIDTH-9:0];
            if (last_byte) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= word_cnt_q[ADDR_W-1:0];
              wr_data_q  <= word_d;
              word_cnt_q <= word_cnt_q + 16'd1;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
          ST_CSUM: begin
            if (csum_ok) begin
              done_q  <= 1'b1;
              flash_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      // Entering or staying in ERROR keeps the failure flag sticky.
      if (state_d == ST_ERROR) err_q <= 1'b1;
    end
  end

  program_ram #(
    .WIDTH  (ROM_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en_q),
    .i_waddr (wr_addr_q),
    .i_wdata (wr_data_q),
    .i_raddr (i_pc[ADDR_W-1:0]),
    .o_rdata (ram_rdata)
  );

  assign o_ir           = rd_ok_q ? ram_rdata : ROM_WIDTH'(NOP_WORD);
  assign o_is_flashing  = flash_q;
  assign o_load_done    = done_q;
  assign o_error        = err_q;
  assign o_words_loaded = word_cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frame stimulus for program_loader,
// checked against a frame-level model of memory and status flags.
module tb_program_loader;

  localparam int T = 40;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [15:0] i_pc;
  logic [23:0] o_ir;
  logic        o_is_flashing;
  logic        o_load_done;
  logic        o_error;
  logic [15:0] o_words_loaded;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  logic [23:0] model_mem [int];
  logic [23:0] words [$];

  program_loader #(
    .ROM_WIDTH      (24),
    .DEPTH          (4096),
    .ADDR_W         (12),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .i_pc           (i_pc),
    .o_ir           (o_ir),
    .o_is_flashing  (o_is_flashing),
    .o_load_done    (o_load_done),
    .o_error        (o_error),
    .o_words_loaded (o_words_loaded)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_load_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit bad, input int gmax);
    int unsigned s;
    int          d0;
    logic [7:0]  b;
    logic [7:0]  cs;
    s  = 0;
    d0 = done_cnt;
    send_byte(8'hA5, 0);
    chk("flash_rise", 32'(o_is_flashing), 1);
    chk("err_clear", 32'(o_error), 0);
    send_byte(8'(words.size() >> 8), $urandom_range(0, gmax));
    send_byte(8'(words.size()), $urandom_range(0, gmax));
    foreach (words[i]) begin
      for (int k = 2; k >= 0; k--) begin
        b = words[i][8*k +: 8];
        s += b;
        send_byte(b, $urandom_range(0, gmax));
      end
      model_mem[i] = words[i];
    end
    cs = 8'(256 - (s % 256));
    if (bad) cs = cs + 8'd1;
    send_byte(cs, $urandom_range(0, gmax));
    chk("done_pulse", 32'(o_load_done), 32'(!bad));
    chk("flash_after", 32'(o_is_flashing), 32'(bad));
    chk("err_after", 32'(o_error), 32'(bad));
    chk("words_loaded", 32'(o_words_loaded), 32'(words.size()));
    @(negedge i_clk);
    chk("done_count", 32'(done_cnt - d0), 32'(!bad));
    chk("done_low", 32'(o_load_done), 0);
  endtask

  task automatic fetch(input int pc, input bit held);
    logic [23:0] exp;
    i_pc = 16'(pc);
    @(negedge i_clk);
    exp = (held || pc >= 4096) ? 24'h0 : model_mem[pc];
    chk($sformatf("ir_pc%0d", pc), 32'(o_ir), 32'(exp));
  endtask

  initial begin
    int          n;
    bit          bad;
    logic [23:0] w0;
    i_rst      = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_pc       = 16'd0;
    repeat (3) @(negedge i_clk);
    chk("rst_ir", 32'(o_ir), 0);
    chk("rst_flash", 32'(o_is_flashing), 0);
    chk("rst_err", 32'(o_error), 0);
    chk("rst_done", 32'(o_load_done), 0);
    chk("rst_words", 32'(o_words_loaded), 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    words = '{24'h123456, 24'hABCDEF};
    send_frame(1'b0, 0);
    fetch(1, 1'b0);
    fetch(0, 1'b0);

    send_frame(1'b1, 0);
    fetch(1, 1'b1);
    repeat (5) @(negedge i_clk);
    chk("err_sticky", 32'(o_error), 1);
    chk("flash_held", 32'(o_is_flashing), 1);

    send_frame(1'b0, 0);
    fetch(1, 1'b0);

    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    chk("len_err", 32'(o_error), 1);
    chk("len_flash", 32'(o_is_flashing), 1);
    chk("len_words", 32'(o_words_loaded), 0);

    words = {};
    send_frame(1'b0, 0);
    fetch(0, 1'b0);
    fetch(1, 1'b0);

    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    repeat (T - 1) @(negedge i_clk);
    chk("tmo_early", 32'(o_error), 0);
    @(negedge i_clk);
    chk("tmo_err", 32'(o_error), 1);
    chk("tmo_flash", 32'(o_is_flashing), 1);
    chk("tmo_words", 32'(o_words_loaded), 0);

    repeat (4) begin
      n   = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      words = {};
      for (int i = 0; i < n; i++) words.push_back(24'($urandom));
      send_frame(bad, 3);
      for (int i = 0; i < n; i++) fetch(i, bad);
    end

    w0 = 24'($urandom);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(w0[23:16], 0);
    send_byte(w0[15:8], 0);
    send_byte(w0[7:0], 0);
    send_byte(8'h77, 0);
    model_mem[0] = w0;
    chk("mid_flash", 32'(o_is_flashing), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_mid_flash", 32'(o_is_flashing), 0);
    chk("rst_mid_words", 32'(o_words_loaded), 0);
    chk("rst_mid_err", 32'(o_error), 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    fetch(0, 1'b0);
    fetch(5000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
